// File: rtl/formula_worker_scheduler.sv
// Dispatches (a,b,c) triples to a pool of non-pipelined formula workers and returns results in acceptance order.
// Optional build macro SCHED_STATS_EN adds stall_cnt and max_inflight statistics outputs.
module formula_worker_scheduler #(
    parameter int N_WORKERS = 4,
    parameter int W         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arg_vld,
    output logic                   arg_rdy,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [W-1:0]           c,
    output logic                   res_vld,
    output logic [W-1:0]           res,
    output logic [N_WORKERS-1:0]   wrk_arg_vld,
    output logic [N_WORKERS*W-1:0] wrk_a,
    output logic [N_WORKERS*W-1:0] wrk_b,
    output logic [N_WORKERS*W-1:0] wrk_c,
    input  logic [N_WORKERS-1:0]   wrk_res_vld,
    input  logic [N_WORKERS*W-1:0] wrk_res
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                      stall_cnt,
    output logic [$clog2(N_WORKERS+1)-1:0]   max_inflight
`endif
);

    localparam int PW = $clog2(N_WORKERS);
    localparam int CW = $clog2(N_WORKERS + 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_DONE = 2'd2
    } wstate_t;

    wstate_t        wst  [N_WORKERS];
    logic [W-1:0]   hold [N_WORKERS];
    logic [PW-1:0]  order_q [N_WORKERS];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic [N_WORKERS-1:0] idle_vec;
    logic [PW-1:0]        sel;
    logic [PW-1:0]        head;
    logic                 accept;
    logic                 retire;
    logic                 head_done;
    logic                 head_bypass;
    logic [W-1:0]         retire_val;

    always_comb begin
        idle_vec = '0;
        for (int i = 0; i < N_WORKERS; i++) begin
            idle_vec[i] = (wst[i] == W_IDLE);
        end
        sel = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--) begin
            if (idle_vec[i]) sel = PW'(i);
        end
    end

    assign arg_rdy = |idle_vec;
    assign accept  = arg_vld && arg_rdy;
    assign head    = order_q[rd_ptr];

    // A result arriving for the head worker retires immediately instead of parking in hold first.
    assign head_done   = (wst[head] == W_DONE);
    assign head_bypass = (wst[head] == W_BUSY) && wrk_res_vld[head];
    assign retire      = (count != '0) && (head_done || head_bypass);
    assign retire_val  = head_done ? hold[head] : wrk_res[int'(head)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_WORKERS; i++) begin
                wst[i]     <= W_IDLE;
                hold[i]    <= '0;
                order_q[i] <= '0;
            end
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            res_vld     <= 1'b0;
            res         <= '0;
            wrk_arg_vld <= '0;
            wrk_a       <= '0;
            wrk_b       <= '0;
            wrk_c       <= '0;
        end else begin
            wrk_arg_vld <= '0;
            res_vld     <= 1'b0;

            for (int i = 0; i < N_WORKERS; i++) begin
                if (wst[i] == W_BUSY && wrk_res_vld[i]) begin
                    wst[i]  <= W_DONE;
                    hold[i] <= wrk_res[i*W +: W];
                end
            end

            // Placed after the latch loop so a bypassed head goes straight to IDLE.
            if (retire) begin
                res       <= retire_val;
                res_vld   <= 1'b1;
                wst[head] <= W_IDLE;
                rd_ptr    <= (rd_ptr == PW'(N_WORKERS - 1)) ? '0 : rd_ptr + PW'(1);
            end

            if (accept) begin
                wst[sel]            <= W_BUSY;
                wrk_a[int'(sel)*W +: W] <= a;
                wrk_b[int'(sel)*W +: W] <= b;
                wrk_c[int'(sel)*W +: W] <= c;
                wrk_arg_vld[sel]    <= 1'b1;
                order_q[wr_ptr]     <= sel;
                wr_ptr              <= (wr_ptr == PW'(N_WORKERS - 1)) ? '0 : wr_ptr + PW'(1);
            end

            count <= count + CW'(accept) - CW'(retire);
        end
    end

`ifdef SCHED_STATS_EN
    logic [CW-1:0] inflight;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < N_WORKERS; i++) begin
            if (!idle_vec[i]) inflight = inflight + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            max_inflight <= '0;
        end else begin
            if (arg_vld && !arg_rdy && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (inflight > max_inflight) max_inflight <= inflight;
        end
    end
`endif

endmodule

// File: doc/formula_worker_scheduler.md
Name: formula_worker_scheduler

Overview:
Schedules a small pool of FSM-based formula workers (formula_1_impl_1_top, formula_1_impl_2_top or formula_2_top class, non-pipelined) behind a single valid/ready argument stream. Each accepted (a,b,c) triple goes to a free worker. Results return to the output stream in strict acceptance order, even when workers finish out of order. Input is stalled (arg_rdy low) when every worker is busy. The block replaces the idealized 50-instance distributor with N_WORKERS instances plus backpressure.

Parameters:
N_WORKERS, 4, number of worker instances driven; legal range 2..16
W, 32, argument/result width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
arg_vld  in  1  input triple valid
arg_rdy  out  1  scheduler can accept a triple this cycle
a  in  W  argument a
b  in  W  argument b
c  in  W  argument c
res_vld  out  1  one-cycle pulse, res valid
res  out  W  result, in acceptance order
wrk_arg_vld  out  N_WORKERS  per-worker start pulse
wrk_a  out  N_WORKERS*W  per-worker a; worker i uses slice [i*W +: W]
wrk_b  out  N_WORKERS*W  per-worker b
wrk_c  out  N_WORKERS*W  per-worker c
wrk_res_vld  in  N_WORKERS  per-worker result pulse
wrk_res  in  N_WORKERS*W  per-worker result

Behaviour:
- Reset: busy[] = 0, held[] = 0, order FIFO empty, wrk_arg_vld = 0, res_vld = 0, res = 0, wrk_a/b/c = 0.
- Worker states, 2-bit per worker:
  - IDLE → BUSY on issue.
  - BUSY → DONE on wrk_res_vld[i]; result is latched into hold register i.
  - DONE → IDLE when retired.
  - A worker is free only in IDLE.
- arg_rdy = any worker IDLE. It is combinational from registered state only and does not depend on arg_vld.
- Accept when arg_vld & arg_rdy:
  - Select the lowest-index IDLE worker k.
  - Register a/b/c into wrk_a/b/c slice k.
  - Pulse wrk_arg_vld[k] on the next cycle.
  - Push k into the order FIFO (depth N_WORKERS, pointers wrap modulo N_WORKERS).
  - Issue latency: 1 cycle.
- A worker retired in cycle t becomes IDLE at t+1. It is selectable for a new accept no earlier than t+1. There is no same-cycle free-and-reuse bypass.
- Retire:
  - Condition: FIFO not empty, and worker head is in DONE.
  - Action: res <= hold[head], res_vld <= 1, pop FIFO, worker head → IDLE.
  - At most one retire per cycle.
  - Minimum latency, wrk_res_vld to res_vld: 1 cycle if the worker is at the head.
- Result latching and retire latency:
  - wrk_res_vld for a worker not at the head is latched and held; it retires when it reaches the head.
  - Total latency from accept to res_vld = 1 + worker latency + 1, minimum.
- Simultaneous push and pop of the FIFO in one cycle are both performed.
- Ordering: res sequence equals acceptance sequence, always.
- wrk_res_vld[i] while worker i is not BUSY: ignored; no state change.
- Reset mid-operation: all state clears in one cycle. Workers share rst, so in-flight results are discarded. No res_vld is produced after reset for pre-reset arguments.
- wrk_arg_vld bits are single-cycle pulses, and at most one is set per cycle.
- Throughput: sustained 1 triple/cycle when N_WORKERS ≥ worker latency + 2. Otherwise arg_rdy stalls.

Optional Feature:
SCHED_STATS_EN:
- Defined: adds output port stall_cnt (32 bits) and output port max_inflight ($clog2(N_WORKERS+1) bits).
  - stall_cnt counts cycles with arg_vld & !arg_rdy; it saturates at all-ones.
  - max_inflight is the high-water mark of non-IDLE workers.
  - Both clear on rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Bench setup: N_WORKERS=4, behavioural workers with fixed latency 10 that return a+b+c.
- Single triple (1,2,3) after reset → wrk_arg_vld[0] pulses 1 cycle after accept; res_vld with res=6 exactly 12 cycles after accept; arg_rdy stays 1.
- Burst of 6 back-to-back triples (i,0,0), i=1..6 → arg_rdy drops after the 4th accept. The 5th is accepted in the cycle after the first retire + 1. Outputs are 1..6 in order, each res_vld a single-cycle pulse.
- Out-of-order completion: worker latencies 20,5,5,5. Send 4 triples → workers 1–3 finish first, but res order is triple0, triple1, triple2, triple3. Triples 1–3 retire on consecutive cycles right after triple0.
- Spurious wrk_res_vld[2] while worker 2 is IDLE → no res_vld, arg_rdy unchanged, the following triple still returns the correct value.
- Reset asserted while 3 workers are busy → next cycle arg_rdy=1, res_vld=0. The first post-reset triple (7,7,7) yields res=21 via worker 0. No stale result appears.
- SCHED_STATS_EN: hold arg_vld high for 10 cycles with all workers busy → stall_cnt=10, max_inflight=4.
